// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the BCD-to-binary converter:
//               the 4-bit BCD digit type, the converter FSM state encoding,
//               the digit adjustment constants and a digit-validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Converter control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } bcd_state_e;

  // Largest legal decimal digit.
  localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
  // After a right shift, a digit at or above this value received a bit
  // worth 10 from its upper neighbour, which must count as 5 here.
  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;
  // Correction that turns the shifted-in 8 into 5.
  localparam bcd_digit_t BCD_ADJ        = 4'd3;

  // True when the digit is a legal decimal digit (0..9).
  function automatic logic digit_valid(input bcd_digit_t d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_to_binary_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_if
// Description : Request/result bundle of the BCD-to-binary converter.
//               master : requester (drives load and the four digits,
//                        observes binary/busy/done/err)
//               slave  : converter
// Signals     : load        start request (sampled only while idle)
//               ones..thousands  BCD digits 0..3
//               binary      converted value, held until the next completion
//               busy        conversion in progress
//               done        one-cycle completion pulse
//               err         invalid-digit flag, valid with done
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_to_binary_if #(
  parameter int BIN_W = 14
);

  logic                 load;
  bcd_pkg::bcd_digit_t  ones;
  bcd_pkg::bcd_digit_t  tens;
  bcd_pkg::bcd_digit_t  hundreds;
  bcd_pkg::bcd_digit_t  thousands;
  logic [BIN_W-1:0]     binary;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output load, ones, tens, hundreds, thousands,
    input  binary, busy, done, err
  );

  modport slave (
    input  load, ones, tens, hundreds, thousands,
    output binary, busy, done, err
  );

endinterface : bcd_to_binary_if
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Per-digit correction step of the reverse double-dabble
//               algorithm. A digit that reads 8 or more after the right
//               shift has 3 subtracted; smaller digits pass unchanged.
// Ports       : digit_in   shifted BCD digit
//               digit_out  corrected BCD digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in - BCD_ADJ)
                                                  : digit_in;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary
// Description : Sequential BCD-to-binary converter (reverse double dabble).
//               A load in IDLE captures the digits, then BIN_W CONVERT
//               cycles each shift {bcd,acc} right by one and correct every
//               BCD digit that reads >= 8. The accumulator then holds the
//               binary value, published with a one-cycle done pulse.
//               Load-to-done latency is BIN_W+1 cycles.
// Parameters  : NUM_DIGITS  number of BCD digits converted (default 4)
//               BIN_W       result width, 2**BIN_W > 10**NUM_DIGITS - 1
// Ports       : clk         clock, rising edge
//               rst_n       asynchronous active-low reset
//               bus         bcd_to_binary_if slave modport
// Options     : BCD2BIN_DIGIT_CHECK_EN - when defined, a load carrying any
//               digit above 9 skips conversion and completes on the next
//               cycle with err=1 and binary=0. When undefined err is tied
//               low and such digits run through the normal algorithm.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  wire             clk,
  input  wire             rst_n,
  bcd_to_binary_if.slave  bus
);

  localparam int              BCD_W    = 4 * NUM_DIGITS;
  localparam int              CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  bcd_state_e        r_state;
  logic [BCD_W-1:0]  r_bcd;
  logic [BIN_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIN_W-1:0]  r_binary;
  logic              r_busy;
  logic              r_done;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic              r_err;
  logic [NUM_DIGITS-1:0] w_digit_bad;
`endif

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  bcd_digit_t        w_port [4];
  logic [BCD_W-1:0]  w_capture;
  logic [BCD_W-1:0]  w_bcd_shift;
  logic [BCD_W-1:0]  w_bcd_adj;
  logic [BIN_W-1:0]  w_acc_shift;

  assign w_port[0] = bus.ones;
  assign w_port[1] = bus.tens;
  assign w_port[2] = bus.hundreds;
  assign w_port[3] = bus.thousands;

  // Joint right shift: the BCD LSB falls into the accumulator MSB and a
  // zero enters the top of the BCD register.
  assign {w_bcd_shift, w_acc_shift} = {r_bcd, r_acc} >> 1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      // Only four digit ports exist; any extra digits capture as zero.
      if (gi < 4) begin : g_port
        assign w_capture[4*gi +: 4] = w_port[gi];
      end else begin : g_pad
        assign w_capture[4*gi +: 4] = 4'd0;
      end

      bcd_digit_adj u_adj (
        .digit_in  (w_bcd_shift[4*gi +: 4]),
        .digit_out (w_bcd_adj[4*gi +: 4])
      );

`ifdef BCD2BIN_DIGIT_CHECK_EN
      assign w_digit_bad[gi] = !digit_valid(w_capture[4*gi +: 4]);
`endif
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_bcd    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_binary <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.load) begin
            r_bcd <= w_capture;
            r_acc <= '0;
            r_cnt <= CNT_LOAD;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (|w_digit_bad) begin
              // Invalid input: report immediately, no conversion.
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_err    <= 1'b1;
              r_binary <= '0;
            end else begin
              r_state  <= ST_CONVERT;
              r_busy   <= 1'b1;
              r_err    <= 1'b0;
            end
`else
            r_state <= ST_CONVERT;
            r_busy  <= 1'b1;
`endif
          end
        end

        ST_CONVERT: begin
          r_bcd <= w_bcd_adj;
          r_acc <= w_acc_shift;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            // Last shift: the accumulator value produced this cycle is
            // the final result.
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_binary <= w_acc_shift;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.binary = r_binary;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign bus.err    = r_err;
`else
  assign bus.err    = 1'b0;
`endif

endmodule : bcd_to_binary
`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_binary
// Description : Self-checking bench for bcd_to_binary: reset state, a table
//               of fixed digit sets, random valid digits against a decimal
//               arithmetic model, and hand-written sequences for load during
//               conversion, reset mid-conversion, invalid digits and
//               continuously held load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int TIMEOUT    = 40;

  logic clk;
  logic rst_n;

  bcd_to_binary_if #(.BIN_W(BIN_W)) bus ();

  bcd_to_binary #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_count = 0;
  bit both_seen  = 0;

  typedef struct {
    int th;
    int h;
    int t;
    int o;
    int exp_bin;
  } vec_t;

  vec_t tbl [8];

  // Decimal value of the four digits.
  function automatic int bcd_model(input int th, input int h, input int t, input int o);
    return 1000 * th + 100 * h + 10 * t + o;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Watch the whole run for overlapping busy/done and count done pulses.
  always @(negedge clk) begin
    if (bus.busy && bus.done) both_seen = 1;
    if (bus.done) done_count++;
  end

  task automatic set_digits(input int th, input int h, input int t, input int o);
    bus.thousands = 4'(th);
    bus.hundreds  = 4'(h);
    bus.tens      = 4'(t);
    bus.ones      = 4'(o);
  endtask

  // One load pulse, then digits scrambled while the converter works.
  // Latency is counted in negedges from the one where load was driven.
  task automatic convert(input string name, input int th, input int h,
                         input int t, input int o, input int exp_lat,
                         input int exp_bin, input bit chk_bin, input bit exp_err);
    int cyc;
    int busy_cyc;
    bit seen;
    int held;
    @(negedge clk);
    set_digits(th, h, t, o);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    set_digits($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
    cyc = 1;
    busy_cyc = 0;
    seen = 0;
    while (!seen && cyc <= TIMEOUT) begin
      if (bus.done) seen = 1;
      else begin
        if (bus.busy) busy_cyc++;
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_latency"}, cyc, exp_lat);
      check({name, "_busy_cycles"}, busy_cyc, exp_lat - 1);
      check({name, "_err"}, int'(bus.err), int'(exp_err));
      held = int'(bus.binary);
      if (chk_bin) check({name, "_binary"}, held, exp_bin);
      @(negedge clk);
      check({name, "_done_one_cycle"}, int'(bus.done), 0);
      check({name, "_binary_held"}, int'(bus.binary), held);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected run completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    int cyc;
    bit seen;
    vec_t bb [3];

    tbl[0] = '{1, 0, 2, 3, 1023};
    tbl[1] = '{9, 9, 9, 9, 9999};
    tbl[2] = '{0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 1};
    tbl[4] = '{9, 0, 0, 0, 9000};
    tbl[5] = '{0, 0, 1, 0, 10};
    tbl[6] = '{8, 1, 9, 2, 8192};
    tbl[7] = '{5, 5, 5, 5, 5555};

    rst_n    = 1'b0;
    bus.load = 1'b0;
    set_digits(0, 0, 0, 0);

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_binary", int'(bus.binary), 0);
    check("rst_busy",   int'(bus.busy),   0);
    check("rst_done",   int'(bus.done),   0);
    check("rst_err",    int'(bus.err),    0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // ---- fixed vectors ----
    for (int i = 0; i < 8; i++) begin
      convert($sformatf("tbl%0d", i), tbl[i].th, tbl[i].h, tbl[i].t, tbl[i].o,
              15, tbl[i].exp_bin, 1, 0);
    end

    // ---- random valid digits against the decimal model ----
    for (int i = 0; i < 25; i++) begin
      int th, h, t, o;
      th = $urandom_range(0, 9);
      h  = $urandom_range(0, 9);
      t  = $urandom_range(0, 9);
      o  = $urandom_range(0, 9);
      convert($sformatf("rnd%0d", i), th, h, t, o, 15, bcd_model(th, h, t, o), 1, 0);
    end

    // ---- load during conversion is ignored ----
    @(negedge clk);
    set_digits(0, 5, 1, 2);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    d0 = done_count;
    repeat (4) @(negedge clk);
    set_digits(0, 7, 7, 7);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    cyc = 6;
    seen = 0;
    while (!seen && cyc <= TIMEOUT) begin
      if (bus.done) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("reload_done_seen", int'(seen), 1);
    check("reload_latency", cyc, 15);
    check("reload_binary", int'(bus.binary), 512);
    repeat (20) @(negedge clk);
    check("reload_single_done", done_count - d0, 1);
    convert("reload_777", 0, 7, 7, 7, 15, 777, 1, 0);

    // ---- reset in the middle of a conversion ----
    @(negedge clk);
    set_digits(0, 9, 9, 9);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    d0 = done_count;
    repeat (6) @(negedge clk);
    check("midrst_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   int'(bus.busy),   0);
    check("midrst_done",   int'(bus.done),   0);
    check("midrst_binary", int'(bus.binary), 0);
    check("midrst_err",    int'(bus.err),    0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    convert("after_rst_42", 0, 0, 4, 2, 15, 42, 1, 0);
    check("midrst_done_count", done_count - d0, 1);

    // ---- invalid digit ----
`ifdef BCD2BIN_DIGIT_CHECK_EN
    convert("bad_tens", 1, 2, 10, 3, 1, 0, 1, 1);
    check("bad_err_held", int'(bus.err), 1);
    convert("err_clears", 0, 0, 0, 7, 15, 7, 1, 0);
`else
    convert("bad_tens", 1, 2, 10, 3, 15, 0, 0, 0);
`endif

    // ---- load held high continuously ----
    for (int i = 0; i < 3; i++) begin
      bb[i].th = $urandom_range(0, 9);
      bb[i].h  = $urandom_range(0, 9);
      bb[i].t  = $urandom_range(0, 9);
      bb[i].o  = $urandom_range(0, 9);
      bb[i].exp_bin = bcd_model(bb[i].th, bb[i].h, bb[i].t, bb[i].o);
    end
    @(negedge clk);
    set_digits(bb[0].th, bb[0].h, bb[0].t, bb[0].o);
    bus.load = 1'b1;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      seen = 0;
      while (!seen && cyc <= TIMEOUT) begin
        @(negedge clk);
        cyc++;
        if (bus.done) seen = 1;
      end
      check($sformatf("b2b%0d_done_seen", i), int'(seen), 1);
      check($sformatf("b2b%0d_latency", i), cyc, (i == 0) ? 15 : 16);
      check($sformatf("b2b%0d_binary", i), int'(bus.binary), bb[i].exp_bin);
      if (i < 2) set_digits(bb[i+1].th, bb[i+1].h, bb[i+1].t, bb[i+1].o);
      else bus.load = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d_idle_gap", i), int'(bus.busy), 0);
      @(negedge clk);
      check($sformatf("b2b%0d_restart", i), int'(bus.busy), (i < 2) ? 1 : 0);
      cyc = 2;
    end

    check("busy_done_exclusive", int'(both_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bcd_to_binary
`default_nettype wire
